// File: rtl/axi_m2s_mn.sv
// Slave-side AXI request mux: arbitrates AW/AR from NUM_MASTER masters onto one
// slave port and steers W beats in AW-acceptance order via a small index FIFO.

module axi_m2s_mn_ach #(
  parameter int NUM_MASTER = 3,
  parameter int MIDX_W = 2,
  parameter int W_ID = 4,
  parameter int W_ADDR = 32,
  parameter logic [W_ADDR-1:0] ADDR_BASE = '0,
  parameter int ADDR_LENGTH = 12
)(
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_mode,
  input  logic                           i_block,
  input  logic [NUM_MASTER*W_ID-1:0]     i_id,
  input  logic [NUM_MASTER*W_ADDR-1:0]   i_addr,
  input  logic [NUM_MASTER*8-1:0]        i_len,
  input  logic [NUM_MASTER*3-1:0]        i_size,
  input  logic [NUM_MASTER*2-1:0]        i_burst,
  input  logic [NUM_MASTER-1:0]          i_valid,
  output logic [NUM_MASTER-1:0]          o_ready,
  output logic [MIDX_W+W_ID-1:0]         o_id,
  output logic [W_ADDR-1:0]              o_addr,
  output logic [7:0]                     o_len,
  output logic [2:0]                     o_size,
  output logic [1:0]                     o_burst,
  output logic                           o_valid,
  input  logic                           i_ready
);
  typedef enum logic {ST_IDLE, ST_GRANT} st_t;
  st_t                   r_st;
  logic [NUM_MASTER-1:0] r_gnt;
  logic [MIDX_W-1:0]     r_idx, r_rr;
  logic [NUM_MASTER-1:0] w_req;
  logic [MIDX_W-1:0]     w_pick;
  logic                  w_found;

  always_comb begin
    for (int i = 0; i < NUM_MASTER; i++)
      w_req[i] = i_valid[i] &&
        (i_addr[i*W_ADDR+ADDR_LENGTH +: W_ADDR-ADDR_LENGTH] == ADDR_BASE[W_ADDR-1:ADDR_LENGTH]);
  end

  // Round-robin scans upward from r_rr with wrap; fixed priority scans from 0.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NUM_MASTER; k++) begin
      int j;
      j = i_mode ? int'(r_rr) + k : k;
      if (j >= NUM_MASTER) j = j - NUM_MASTER;
      if (!w_found && w_req[j]) begin
        w_found = 1'b1;
        w_pick  = MIDX_W'(j);
      end
    end
  end

  // One-hot AND-OR mux; an idle channel presents all-zero payload.
  always_comb begin
    o_id    = '0;
    o_addr  = '0;
    o_len   = '0;
    o_size  = '0;
    o_burst = '0;
    for (int i = 0; i < NUM_MASTER; i++) begin
      if (r_gnt[i]) begin
        o_id    = {MIDX_W'(i), i_id[i*W_ID +: W_ID]};
        o_addr  = i_addr[i*W_ADDR +: W_ADDR];
        o_len   = i_len[i*8 +: 8];
        o_size  = i_size[i*3 +: 3];
        o_burst = i_burst[i*2 +: 2];
      end
    end
  end

  assign o_valid = |(r_gnt & i_valid);
  assign o_ready = r_gnt & {NUM_MASTER{i_ready}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st  <= ST_IDLE;
      r_gnt <= '0;
      r_idx <= '0;
      r_rr  <= '0;
    end else begin
      case (r_st)
        ST_IDLE: if (w_found && !i_block) begin
          r_st  <= ST_GRANT;
          r_gnt <= NUM_MASTER'(1) << w_pick;
          r_idx <= w_pick;
        end
        ST_GRANT: if (o_valid && i_ready) begin
          r_st  <= ST_IDLE;
          r_gnt <= '0;
          r_idx <= '0;
          r_rr  <= (r_idx == MIDX_W'(NUM_MASTER-1)) ? '0 : r_idx + MIDX_W'(1);
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end
endmodule

module axi_m2s_mn #(
  parameter int NUM_MASTER = 3,
  parameter int MIDX_W = 2,
  parameter int W_ID = 4,
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter logic [W_ADDR-1:0] ADDR_BASE = '0,
  parameter int ADDR_LENGTH = 12,
  parameter int WFIFO_DEPTH = 4
)(
  input  logic                               AXI_CLK,
  input  logic                               AXI_RST,
  input  logic                               ARB_MODE,
  input  logic [NUM_MASTER*W_ID-1:0]         M_AWID,
  input  logic [NUM_MASTER*W_ADDR-1:0]       M_AWADDR,
  input  logic [NUM_MASTER*8-1:0]            M_AWLEN,
  input  logic [NUM_MASTER*3-1:0]            M_AWSIZE,
  input  logic [NUM_MASTER*2-1:0]            M_AWBURST,
  input  logic [NUM_MASTER-1:0]              M_AWVALID,
  output logic [NUM_MASTER-1:0]              M_AWREADY,
  input  logic [NUM_MASTER*W_DATA-1:0]       M_WDATA,
  input  logic [NUM_MASTER*(W_DATA/8)-1:0]   M_WSTRB,
  input  logic [NUM_MASTER-1:0]              M_WLAST,
  input  logic [NUM_MASTER-1:0]              M_WVALID,
  output logic [NUM_MASTER-1:0]              M_WREADY,
  input  logic [NUM_MASTER*W_ID-1:0]         M_ARID,
  input  logic [NUM_MASTER*W_ADDR-1:0]       M_ARADDR,
  input  logic [NUM_MASTER*8-1:0]            M_ARLEN,
  input  logic [NUM_MASTER*3-1:0]            M_ARSIZE,
  input  logic [NUM_MASTER*2-1:0]            M_ARBURST,
  input  logic [NUM_MASTER-1:0]              M_ARVALID,
  output logic [NUM_MASTER-1:0]              M_ARREADY,
  output logic [MIDX_W+W_ID-1:0]             S_AWID,
  output logic [W_ADDR-1:0]                  S_AWADDR,
  output logic [7:0]                         S_AWLEN,
  output logic [2:0]                         S_AWSIZE,
  output logic [1:0]                         S_AWBURST,
  output logic                               S_AWVALID,
  input  logic                               S_AWREADY,
  output logic [MIDX_W+W_ID-1:0]             S_WID,
  output logic [W_DATA-1:0]                  S_WDATA,
  output logic [W_DATA/8-1:0]                S_WSTRB,
  output logic                               S_WLAST,
  output logic                               S_WVALID,
  input  logic                               S_WREADY,
  output logic [MIDX_W+W_ID-1:0]             S_ARID,
  output logic [W_ADDR-1:0]                  S_ARADDR,
  output logic [7:0]                         S_ARLEN,
  output logic [2:0]                         S_ARSIZE,
  output logic [1:0]                         S_ARBURST,
  output logic                               S_ARVALID,
  input  logic                               S_ARREADY,
  output logic [$clog2(WFIFO_DEPTH):0]       WFIFO_COUNT
);
  localparam int FA_W  = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = FA_W + 1;

  logic [MIDX_W-1:0] r_wf_mem [WFIFO_DEPTH];
  logic [FA_W-1:0]   r_wf_wp, r_wf_rp;
  logic [CNT_W-1:0]  r_wf_cnt;
  logic              w_wf_full, w_wf_empty, w_push, w_pop;
  logic [MIDX_W-1:0] w_head, w_aw_idx;

  assign w_wf_full  = (r_wf_cnt == CNT_W'(WFIFO_DEPTH));
  assign w_wf_empty = (r_wf_cnt == '0);
  assign w_head     = r_wf_mem[r_wf_rp];
  assign w_aw_idx   = S_AWID[W_ID +: MIDX_W];
  assign w_push     = S_AWVALID & S_AWREADY;
  assign w_pop      = S_WVALID & S_WREADY & S_WLAST;
  assign WFIFO_COUNT = r_wf_cnt;

  axi_m2s_mn_ach #(.NUM_MASTER(NUM_MASTER), .MIDX_W(MIDX_W), .W_ID(W_ID), .W_ADDR(W_ADDR),
                   .ADDR_BASE(ADDR_BASE), .ADDR_LENGTH(ADDR_LENGTH)) u_aw (
    .i_clk(AXI_CLK), .i_rst(AXI_RST), .i_mode(ARB_MODE), .i_block(w_wf_full),
    .i_id(M_AWID), .i_addr(M_AWADDR), .i_len(M_AWLEN), .i_size(M_AWSIZE), .i_burst(M_AWBURST),
    .i_valid(M_AWVALID), .o_ready(M_AWREADY),
    .o_id(S_AWID), .o_addr(S_AWADDR), .o_len(S_AWLEN), .o_size(S_AWSIZE), .o_burst(S_AWBURST),
    .o_valid(S_AWVALID), .i_ready(S_AWREADY));

  axi_m2s_mn_ach #(.NUM_MASTER(NUM_MASTER), .MIDX_W(MIDX_W), .W_ID(W_ID), .W_ADDR(W_ADDR),
                   .ADDR_BASE(ADDR_BASE), .ADDR_LENGTH(ADDR_LENGTH)) u_ar (
    .i_clk(AXI_CLK), .i_rst(AXI_RST), .i_mode(ARB_MODE), .i_block(1'b0),
    .i_id(M_ARID), .i_addr(M_ARADDR), .i_len(M_ARLEN), .i_size(M_ARSIZE), .i_burst(M_ARBURST),
    .i_valid(M_ARVALID), .o_ready(M_ARREADY),
    .o_id(S_ARID), .o_addr(S_ARADDR), .o_len(S_ARLEN), .o_size(S_ARSIZE), .o_burst(S_ARBURST),
    .o_valid(S_ARVALID), .i_ready(S_ARREADY));

  // Write-order FIFO: entry pushed on AW accept, popped on the WLAST beat.
  always_ff @(posedge AXI_CLK) begin
    if (AXI_RST) begin
      r_wf_wp  <= '0;
      r_wf_rp  <= '0;
      r_wf_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wf_mem[r_wf_wp] <= w_aw_idx;
        r_wf_wp <= r_wf_wp + FA_W'(1);
      end
      if (w_pop) r_wf_rp <= r_wf_rp + FA_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_wf_cnt <= r_wf_cnt + CNT_W'(1);
        2'b01:   r_wf_cnt <= r_wf_cnt - CNT_W'(1);
        default: r_wf_cnt <= r_wf_cnt;
      endcase
    end
  end

  always_comb begin
    S_WDATA  = '0;
    S_WSTRB  = '0;
    S_WLAST  = 1'b0;
    S_WVALID = 1'b0;
    M_WREADY = '0;
    if (!w_wf_empty) begin
      for (int i = 0; i < NUM_MASTER; i++) begin
        if (w_head == MIDX_W'(i)) begin
          S_WDATA     = M_WDATA[i*W_DATA +: W_DATA];
          S_WSTRB     = M_WSTRB[i*(W_DATA/8) +: W_DATA/8];
          S_WLAST     = M_WLAST[i];
          S_WVALID    = M_WVALID[i];
          M_WREADY[i] = S_WREADY;
        end
      end
    end
  end

  assign S_WID = w_wf_empty ? '0 : {w_head, {W_ID{1'b0}}};
endmodule

// File: tb/tb_axi_m2s_mn.sv
// Bench for axi_m2s_mn: stimulus pushes expected AW/W/AR transfers into queues,
// a negedge monitor pops and compares on every slave-side handshake.

module tb_axi_m2s_mn;
  logic        clk = 1'b0, rst = 1'b1, mode = 1'b0;
  logic [11:0] awid = '0, arid = '0;
  logic [95:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [23:0] awlen = '0, arlen = '0;
  logic [8:0]  awsize = '0, arsize = '0;
  logic [5:0]  awburst = '0, arburst = '0;
  logic [11:0] wstrb = '0;
  logic [2:0]  awvalid = '0, awready, wlast = '0, wvalid = '0, wready, arvalid = '0, arready;
  logic [5:0]  s_awid, s_wid, s_arid;
  logic [31:0] s_awaddr, s_araddr, s_wdata;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize, wcnt;
  logic [1:0]  s_awburst, s_arburst;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_wvalid, s_wlast, s_arvalid;
  logic        s_awready = 1'b1, s_wready = 1'b1, s_arready = 1'b1;

  int n_vec = 0, n_err = 0;
  logic [45:0] q_aw[$], q_ar[$];
  logic [42:0] q_w[$];

  axi_m2s_mn dut (
    .AXI_CLK(clk), .AXI_RST(rst), .ARB_MODE(mode),
    .M_AWID(awid), .M_AWADDR(awaddr), .M_AWLEN(awlen), .M_AWSIZE(awsize), .M_AWBURST(awburst),
    .M_AWVALID(awvalid), .M_AWREADY(awready),
    .M_WDATA(wdata), .M_WSTRB(wstrb), .M_WLAST(wlast), .M_WVALID(wvalid), .M_WREADY(wready),
    .M_ARID(arid), .M_ARADDR(araddr), .M_ARLEN(arlen), .M_ARSIZE(arsize), .M_ARBURST(arburst),
    .M_ARVALID(arvalid), .M_ARREADY(arready),
    .S_AWID(s_awid), .S_AWADDR(s_awaddr), .S_AWLEN(s_awlen), .S_AWSIZE(s_awsize),
    .S_AWBURST(s_awburst), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
    .S_WID(s_wid), .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WLAST(s_wlast),
    .S_WVALID(s_wvalid), .S_WREADY(s_wready),
    .S_ARID(s_arid), .S_ARADDR(s_araddr), .S_ARLEN(s_arlen), .S_ARSIZE(s_arsize),
    .S_ARBURST(s_arburst), .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
    .WFIFO_COUNT(wcnt));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_aw(input int m, input logic [3:0] id, input logic [31:0] a, input logic [7:0] l);
    awid[m*4 +: 4] = id; awaddr[m*32 +: 32] = a; awlen[m*8 +: 8] = l;
    awsize[m*3 +: 3] = 3'd2; awburst[m*2 +: 2] = 2'b01;
  endtask

  task automatic set_ar(input int m, input logic [3:0] id, input logic [31:0] a, input logic [7:0] l);
    arid[m*4 +: 4] = id; araddr[m*32 +: 32] = a; arlen[m*8 +: 8] = l;
    arsize[m*3 +: 3] = 3'd2; arburst[m*2 +: 2] = 2'b01;
  endtask

  task automatic set_w(input int m, input logic [31:0] d, input logic l);
    wdata[m*32 +: 32] = d; wstrb[m*4 +: 4] = 4'hF; wlast[m] = l;
  endtask

  task automatic exp_aw(input logic [1:0] m, input logic [3:0] id, input logic [31:0] a, input logic [7:0] l);
    q_aw.push_back({m, id, a, l});
  endtask

  task automatic exp_w(input logic [1:0] m, input logic [31:0] d, input logic l);
    q_w.push_back({m, 4'h0, d, 4'hF, l});
  endtask

  // Scoreboard monitor: compare every slave-side handshake against the queues.
  always @(negedge clk) begin
    if (s_awvalid === 1'b1 && s_awready) begin
      if (q_aw.size() == 0) chk("aw_unexpected", 1, 0);
      else chk("aw_xfer", {s_awid, s_awaddr, s_awlen}, q_aw.pop_front());
    end
    if (s_wvalid === 1'b1 && s_wready) begin
      if (q_w.size() == 0) chk("w_unexpected", 1, 0);
      else chk("w_beat", {s_wid, s_wdata, s_wstrb, s_wlast}, q_w.pop_front());
    end
    if (s_arvalid === 1'b1 && s_arready) begin
      if (q_ar.size() == 0) chk("ar_unexpected", 1, 0);
      else chk("ar_xfer", {s_arid, s_araddr, s_arlen}, q_ar.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chk("rst_vld", {s_awvalid, s_wvalid, s_arvalid}, 3'b000);
    chk("rst_rdy", {awready, wready, arready}, 9'h0);
    chk("rst_cnt", wcnt, 0);
    chk("rst_awid", s_awid, 0);
    rst = 1'b0;

    // Single write from M1
    set_aw(1, 4'h5, 32'h10, 8'd3); exp_aw(2'd1, 4'h5, 32'h10, 8'd3);
    awvalid[1] = 1'b1;
    chk("sw_vld_n", s_awvalid, 0);
    tick();
    chk("sw_vld_n1", s_awvalid, 1);
    chk("sw_awid", s_awid, 6'h15);
    chk("sw_rdy", awready, 3'b010);
    tick(); awvalid[1] = 1'b0;
    chk("sw_cnt1", wcnt, 1);
    for (int b = 0; b < 4; b++) begin
      set_w(1, 32'hA0 + b, b == 3); exp_w(2'd1, 32'hA0 + b, b == 3);
      wvalid[1] = 1'b1;
      chk("sw_cnt_beat", wcnt, 1);
      tick();
    end
    wvalid[1] = 1'b0;
    chk("sw_cnt0", wcnt, 0);

    // Round-robin: all three hold AWVALID
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 1'b1;
    set_aw(0, 4'h1, 32'h100, 8'd0); set_aw(1, 4'h2, 32'h200, 8'd0); set_aw(2, 4'h3, 32'h300, 8'd0);
    exp_aw(2'd0, 4'h1, 32'h100, 0); exp_aw(2'd1, 4'h2, 32'h200, 0);
    exp_aw(2'd2, 4'h3, 32'h300, 0); exp_aw(2'd0, 4'h1, 32'h100, 0);
    awvalid = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rr_vld", s_awvalid, (k % 2 == 1) ? 1 : 0);
    end
    awvalid = 3'b000;
    chk("rr_cnt", wcnt, 4);
    set_w(0, 32'hD0, 1'b1); set_w(1, 32'hD1, 1'b1); set_w(2, 32'hD2, 1'b1);
    exp_w(2'd0, 32'hD0, 1); exp_w(2'd1, 32'hD1, 1); exp_w(2'd2, 32'hD2, 1); exp_w(2'd0, 32'hD0, 1);
    wvalid = 3'b111;
    repeat (4) tick();
    wvalid = 3'b000;
    chk("rr_drain", wcnt, 0);

    // Fixed priority: M0 always wins
    mode = 1'b0;
    repeat (3) exp_aw(2'd0, 4'h1, 32'h100, 0);
    awvalid = 3'b111;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("fx_starve", awready[2:1], 2'b00);
    end
    awvalid = 3'b000;
    chk("fx_cnt", wcnt, 3);
    repeat (3) exp_w(2'd0, 32'hD0, 1);
    wvalid = 3'b001;
    repeat (3) tick();
    wvalid = 3'b000;
    chk("fx_drain", wcnt, 0);

    // FIFO full: 5th AW stalls until a WLAST pop
    set_aw(1, 4'h7, 32'h20, 8'd1);
    repeat (5) exp_aw(2'd1, 4'h7, 32'h20, 8'd1);
    awvalid[1] = 1'b1;
    repeat (8) tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("full_vld", s_awvalid, 0);
    end
    chk("full_cnt", wcnt, 4);
    chk("full_rdy", awready, 3'b000);
    set_w(1, 32'hB0, 1'b1); exp_w(2'd1, 32'hB0, 1);
    wvalid[1] = 1'b1;
    tick(); wvalid[1] = 1'b0;
    chk("full_pop_cnt", wcnt, 3);
    chk("full_pop_vld", s_awvalid, 0);
    tick();
    chk("full_regrant", s_awvalid, 1);
    tick(); awvalid[1] = 1'b0;
    chk("full_cnt2", wcnt, 4);
    wvalid[1] = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      set_w(1, 32'hB0 + b, 1'b1); exp_w(2'd1, 32'hB0 + b, 1);
      tick();
    end
    wvalid[1] = 1'b0;
    chk("full_drain", wcnt, 0);

    // Decode miss on M2
    set_aw(2, 4'h3, 32'h1000, 8'd0);
    awvalid[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("miss_rdy", awready[2], 0);
      chk("miss_vld", s_awvalid, 0);
    end
    awvalid[2] = 1'b0;

    // AR from M2 with slave backpressure
    s_arready = 1'b0;
    set_ar(2, 4'hA, 32'h44, 8'd1); q_ar.push_back({2'd2, 4'hA, 32'h44, 8'd1});
    arvalid[2] = 1'b1;
    repeat (3) tick();
    chk("ar_hold_vld", s_arvalid, 1);
    chk("ar_hold_rdy", arready, 3'b000);
    chk("ar_id", s_arid, 6'h2A);
    s_arready = 1'b1;
    tick(); arvalid[2] = 1'b0;
    chk("ar_done", s_arvalid, 0);

    // Reset in the middle of a 4-beat burst
    mode = 1'b1;
    set_aw(0, 4'h1, 32'h100, 8'd3); exp_aw(2'd0, 4'h1, 32'h100, 8'd3);
    awvalid[0] = 1'b1;
    tick(); tick(); awvalid[0] = 1'b0;
    chk("mr_cnt", wcnt, 1);
    wvalid[0] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      set_w(0, 32'hC0 + b, 1'b0); exp_w(2'd0, 32'hC0 + b, 0);
      tick();
    end
    set_w(0, 32'hC2, 1'b0); exp_w(2'd0, 32'hC2, 0);
    rst = 1'b1;
    tick();
    chk("mr_vld", {s_awvalid, s_wvalid, s_arvalid}, 3'b000);
    chk("mr_rdy", {awready, wready, arready}, 9'h0);
    chk("mr_cnt0", wcnt, 0);
    wvalid[0] = 1'b0;
    rst = 1'b0;
    set_aw(1, 4'h2, 32'h200, 8'd0);
    exp_aw(2'd0, 4'h1, 32'h100, 8'd3);
    awvalid = 3'b011;
    tick();
    chk("mr_rr0", awready, 3'b001);
    tick(); awvalid = 3'b000;
    set_w(0, 32'hC3, 1'b1); exp_w(2'd0, 32'hC3, 1);
    wvalid[0] = 1'b1;
    tick(); wvalid[0] = 1'b0;
    chk("mr_final_cnt", wcnt, 0);

    repeat (2) tick();
    chk("q_aw_left", q_aw.size(), 0);
    chk("q_w_left", q_w.size(), 0);
    chk("q_ar_left", q_ar.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_m2s_mn.md
# axi_m2s_mn

Slave-side request multiplexer for the AXI interconnect: one instance per slave port. It merges AW, W and AR requests from NUM_MASTER masters onto a single slave port. AW and AR use registered grants with fixed-priority or round-robin arbitration. W data is steered in AW-acceptance order through an internal write-order FIFO, so no external W-ordering grant is needed. The block sits between the master-side crossbar fabric and each slave, and extends request IDs with the master index.

## Interface
- NUM_MASTER, 3, number of master ports (2..8)
- MIDX_W, 2, master index width, ≥ clog2(NUM_MASTER)
- W_ID, 4, master ID width
- W_ADDR, 32, address width
- W_DATA, 32, data width; W_STRB = W_DATA/8
- ADDR_BASE, 32'h0, slave base address
- ADDR_LENGTH, 12, low address bits not decoded
- WFIFO_DEPTH, 4, write-order FIFO entries (power of 2, ≥2)

Ports:
- AXI_CLK  in  1  clock
- AXI_RST  in  1  reset; one clock; reset is synchronous and active-high
- ARB_MODE  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- M_AWID/M_AWADDR/M_AWLEN/M_AWSIZE/M_AWBURST  in  NUM_MASTER×(W_ID/W_ADDR/8/3/2)  flattened, master i in slice i
- M_AWVALID  in  NUM_MASTER;  M_AWREADY  out  NUM_MASTER
- M_WDATA/M_WSTRB/M_WLAST  in  NUM_MASTER×(W_DATA/W_STRB/1);  M_WVALID  in  NUM_MASTER;  M_WREADY  out  NUM_MASTER
- M_ARID/M_ARADDR/M_ARLEN/M_ARSIZE/M_ARBURST  in  flattened as AW;  M_ARVALID  in  NUM_MASTER;  M_ARREADY  out  NUM_MASTER
- S_AWID  out  MIDX_W+W_ID  {master index, M_AWID};  S_AWADDR/LEN/SIZE/BURST out;  S_AWVALID out 1;  S_AWREADY in 1
- S_WID  out  MIDX_W+W_ID  {master index, 0};  S_WDATA, S_WSTRB, S_WLAST, S_WVALID out;  S_WREADY in 1
- S_ARID/S_ARADDR/LEN/SIZE/BURST out;  S_ARVALID out 1;  S_ARREADY in 1
- WFIFO_COUNT  out  clog2(WFIFO_DEPTH)+1  write-order FIFO occupancy

## Operation
- Decode: req_aw[i] = M_AWVALID[i] & (M_AWADDR_i[W_ADDR-1:ADDR_LENGTH] == ADDR_BASE[W_ADDR-1:ADDR_LENGTH]). req_ar is defined the same way.
- AW and AR each run an independent two-state FSM.
  - IDLE: no grant; S_xVALID=0; all M_xREADY=0. If any req (AW additionally requires FIFO not full), register a one-hot grant g and go to GRANT.
  - GRANT: S_x* = master g fields; S_xVALID = M_xVALID[g]; M_xREADY[g] = S_xREADY; other READY bits = 0. On S_xVALID & S_xREADY, go to IDLE.
  - Grant is held until the handshake; withdrawal of VALID by master g does not release it.
- Round-robin: the search starts at rr_ptr and ascends modulo NUM_MASTER. On each handshake, rr_ptr = g+1 mod NUM_MASTER. AW and AR keep separate pointers. In fixed mode the pointers are ignored but still update.
- Write-order FIFO:
  - Push index g on the AW handshake.
  - The head selects the W source h: S_W* = master h; S_WVALID = M_WVALID[h]; M_WREADY[h] = S_WREADY.
  - Pop on W handshake with WLAST=1.
  - When empty: S_WVALID=0 and all M_WREADY=0.
- Full: AW arbitration does not grant while count == WFIFO_DEPTH, even if a pop happens in the same cycle.
- Simultaneous push and pop: count is unchanged; pointers wrap modulo WFIFO_DEPTH.

## Timing
- Reset values: all S_*VALID=0, all M_*READY=0, S_* payload = 0, FSMs IDLE, rr_ptrs = 0, FIFO empty, WFIFO_COUNT = 0. Reset asserted mid-burst discards all state at the next edge.
- AW/AR latency: request at cycle N gives grant and S_xVALID at N+1. Earliest handshake is N+1, and the FSM is IDLE at N+2. Peak rate is one address per 2 cycles per channel.
- W path:
  - W data for an AW accepted at cycle N is forwardable from N+1; W is not forwarded in the AW handshake cycle.
  - The W mux is combinational from the head register, with zero added latency.
  - Back-to-back bursts: after a pop at cycle M, the next head is forwarded at M+1.
- Payload outputs are combinational from the grant register and master inputs. S_*VALID never depends combinationally on S_*READY.

## Test plan
- Single write: M1 AW addr 0x0000_0010, LEN=3, ID=5 → S_AWVALID one cycle after request, S_AWID = {2'd1, 4'h5}; 4 W beats on S_W from M1; WFIFO_COUNT 1→0 after the WLAST handshake.
- Round-robin: M0, M1 and M2 hold AWVALID continuously, ARB_MODE=1 → grant order 0,1,2,0; S_AWVALID high every other cycle.
- Fixed priority: same stimulus with ARB_MODE=0 → M0 is granted every time; M1 and M2 are starved while M0 holds VALID.
- FIFO full: WFIFO_DEPTH=4, 4 AWs accepted, no W sent → 5th AW is not granted and WFIFO_COUNT=4. After one WLAST handshake, the 5th AW is granted on the cycle after the pop.
- Decode miss: M2 AWADDR 0x0000_1000 with ADDR_BASE=0 → no grant; M2_AWREADY stays 0.
- Reset mid-burst: AXI_RST asserted during beat 2 of 4 → the next cycle shows all VALID/READY = 0, WFIFO_COUNT = 0, rr_ptr = 0.
